// File: rtl/sram_1rw_ctrl_pkg.sv
// Shared types and helpers for the 1RW SRAM controller and its response FIFO.
package sram_1rw_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_1rw_ctrl_rsp_fifo.sv
// Response FIFO for read data returning from the SRAM; the head entry is held
// in a register so the response data path leaves straight from a flop.
module sram_1rw_ctrl_rsp_fifo
  import sram_1rw_ctrl_pkg::*;
#(
  parameter int  W     = 32,
  parameter int  DEPTH = 3,
  localparam int OW    = occ_width(DEPTH),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [OW-1:0] occ,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          head_load;
  logic [W-1:0]  head_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok = pop && (occ != '0);

  // Next head: the entry behind the popped one, or the incoming word when the
  // FIFO is (or is about to become) otherwise empty.
  always_comb begin
    head_load = 1'b0;
    head_nxt  = din;
    if (pop_ok && (occ > OW'(1))) begin
      head_load = 1'b1;
      head_nxt  = mem[ptr_inc(rd_ptr)];
    end else if (push && ((occ == '0) || (pop_ok && (occ == OW'(1))))) begin
      head_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_ok})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)      mem[wr_ptr] <= din;
    if (head_load) head        <= head_nxt;
  end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Valid/ready initiator for a 1RW synchronous SRAM with a backpressure-safe
// read response FIFO. Define SRAM_1RW_CTRL_INIT_EN to sweep INIT_VALUE into the array after reset.
module sram_1rw_ctrl
  import sram_1rw_ctrl_pkg::*;
#(
  parameter int           W          = 32,
  parameter int           N          = 1024,
  parameter int           RSP_DEPTH  = 3,
  parameter logic [W-1:0] INIT_VALUE = '0,
  localparam int          AW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          req_vld,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [W-1:0]  req_wdata,
  output logic          req_rdy,
  output logic          rsp_vld,
  output logic [W-1:0]  rsp_rdata,
  input  logic          rsp_rdy,
  output logic          init_done,
  output logic [AW-1:0] sram_addr,
  output logic [W-1:0]  sram_din,
  output logic          sram_cs_n,
  output logic          sram_we_n,
  input  logic [W-1:0]  sram_dout
);

  localparam int          OW      = occ_width(RSP_DEPTH);
  localparam logic [OW:0] DEPTH_C = (OW + 1)'(RSP_DEPTH);

  state_t        state;
  logic          inflight_p1;
  logic [OW-1:0] fifo_occ;
  logic [OW:0]   pending;
  logic          accept;
  logic          rd_accept;
  logic          pop;

  // Reserve a FIFO slot for every read still travelling through the macro.
  assign pending   = {1'b0, fifo_occ} + {{OW{1'b0}}, inflight_p1};
  assign req_rdy   = (state == RUN) && (pending < DEPTH_C);
  assign accept    = req_vld && req_rdy;
  assign rd_accept = accept && !req_wr;
  assign rsp_vld   = (fifo_occ != '0);
  assign pop       = rsp_vld && rsp_rdy;

`ifdef SRAM_1RW_CTRL_INIT_EN
  logic          init_wr;
  logic [AW-1:0] init_addr;

  assign sram_cs_n = !(accept || init_wr);
  assign sram_we_n = init_wr ? 1'b0 : !(accept && req_wr);
  assign sram_addr = accept ? req_addr : init_addr;
`else
  assign sram_cs_n = !accept;
  assign sram_we_n = !(accept && req_wr);
  assign sram_addr = req_addr;
`endif
  // Idle data bus parks at INIT_VALUE, which is also what the sweep writes.
  assign sram_din = accept ? req_wdata : INIT_VALUE;

  // Stage p0 -> p1: macro samples the strobe; dout is valid one cycle later.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= INIT;
      init_done   <= 1'b0;
      inflight_p1 <= 1'b0;
`ifdef SRAM_1RW_CTRL_INIT_EN
      init_wr     <= 1'b0;
      init_addr   <= '0;
`endif
    end else begin
      inflight_p1 <= rd_accept;
      case (state)
        INIT: begin
`ifdef SRAM_1RW_CTRL_INIT_EN
          if (!init_wr) begin
            init_wr <= 1'b1;
          end else if (init_addr == AW'(N - 1)) begin
            init_wr   <= 1'b0;
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            init_addr <= init_addr + AW'(1);
          end
`else
          state     <= RUN;
          init_done <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Stage p1 -> p2: captured read data enters the response FIFO.
  sram_1rw_ctrl_rsp_fifo #(
    .W     (W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (inflight_p1),
    .din    (sram_dout),
    .pop    (pop),
    .occ    (fifo_occ),
    .head   (rsp_rdata)
  );

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Scoreboard bench for sram_1rw_ctrl with a behavioural 1RW SRAM attached.
module tb_sram_1rw_ctrl;

  localparam int          W         = 32;
  localparam int          N         = 16;
  localparam int          AW        = 4;
  localparam int          RSP_DEPTH = 3;
  localparam logic [31:0] INIT_VAL  = 32'hA5;
`ifdef SRAM_1RW_CTRL_INIT_EN
  localparam int INIT_CYC = N + 1;
`else
  localparam int INIT_CYC = 1;
`endif

  logic          clk       = 1'b0;
  logic          arst_n    = 1'b0;
  logic          req_vld   = 1'b0;
  logic          req_wr    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          rsp_rdy   = 1'b1;
  logic          req_rdy;
  logic          rsp_vld;
  logic [W-1:0]  rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_din;
  logic          sram_cs_n;
  logic          sram_we_n;
  logic [W-1:0]  sram_dout;

  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          max_out = 0;
  logic [31:0] exp_q [$];
  int          lat_q [$];
  logic [31:0] exp_mem [N];
  logic [31:0] sram_mem [N];
  bit          hold_pend = 0;
  logic [31:0] hold_data;

  sram_1rw_ctrl #(
    .W          (W),
    .N          (N),
    .RSP_DEPTH  (RSP_DEPTH),
    .INIT_VALUE (INIT_VAL)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .req_vld   (req_vld),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rdy   (req_rdy),
    .rsp_vld   (rsp_vld),
    .rsp_rdata (rsp_rdata),
    .rsp_rdy   (rsp_rdy),
    .init_done (init_done),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_cs_n (sram_cs_n),
    .sram_we_n (sram_we_n),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > max_out) max_out <= exp_q.size();
    if (!sram_cs_n) begin
      if (!sram_we_n) sram_mem[sram_addr] <= sram_din;
      else            sram_dout <= sram_mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each consumed response against the scoreboard head.
  always @(negedge clk) begin
    if (arst_n) begin
      if (hold_pend) begin
        check("rsp_hold_vld", {31'd0, rsp_vld}, 32'd1);
        check("rsp_hold_data", rsp_rdata, hold_data);
      end
      hold_pend = 0;
      if (rsp_vld && !rsp_rdy) begin
        hold_pend = 1;
        hold_data = rsp_rdata;
      end
      if (rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %h with no read outstanding", rsp_rdata);
        end else begin
          logic [31:0] e;
          int          l;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("rsp_data", rsp_rdata, e);
          if (l >= 0) check("rsp_latency_cycle", 32'(cyc), 32'(l));
        end
      end
    end else begin
      hold_pend = 0;
    end
  end

  task automatic issue(input logic wr, input int a, input logic [31:0] d,
                       input bit lat_chk, input bit strict);
    int n;
    n = 0;
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = AW'(a);
    req_wdata = d;
    @(negedge clk);
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: req_rdy stayed %b for addr %0d, required 1", req_rdy, a);
    end else begin
      if (strict) check("req_rdy_stall_cycles", 32'(n), 32'd0);
      if (wr) exp_mem[a] = d;
      else begin
        exp_q.push_back(exp_mem[a]);
        lat_q.push_back(lat_chk ? cyc + 2 : -1);
      end
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_values();
    @(negedge clk);
    check("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_cs_n", {31'd0, sram_cs_n}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
  endtask

  // Called with reset just released, #1 after a posedge (cycle 0).
  task automatic init_check();
    for (int k = 0; k <= INIT_CYC; k++) begin
      @(negedge clk);
      check("init_done", {31'd0, init_done}, (k == INIT_CYC) ? 32'd1 : 32'd0);
      check("init_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      if (k < INIT_CYC) begin
        check("init_req_rdy", {31'd0, req_rdy}, 32'd0);
`ifdef SRAM_1RW_CTRL_INIT_EN
        check("init_cs_n", {31'd0, sram_cs_n}, (k == 0) ? 32'd1 : 32'd0);
        if (k > 0) begin
          check("init_we_n", {31'd0, sram_we_n}, 32'd0);
          check("init_addr", {28'd0, sram_addr}, 32'(k - 1));
          check("init_din", sram_din, INIT_VAL);
        end
`else
        check("init_cs_n", {31'd0, sram_cs_n}, 32'd1);
`endif
      end
    end
`ifdef SRAM_1RW_CTRL_INIT_EN
    for (int a = 0; a < N; a++) exp_mem[a] = INIT_VAL;
`endif
  endtask

  initial begin
    for (int a = 0; a < N; a++) exp_mem[a] = 'x;
    repeat (3) @(posedge clk);
    reset_values();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    init_check();

    // Read back the swept value (or a freshly written one without the sweep).
`ifndef SRAM_1RW_CTRL_INIT_EN
    issue(1'b1, 7, INIT_VAL, 0, 0);
`endif
    issue(1'b0, 7, '0, 1, 0);
    drain();

    // Read immediately after a write to the same address.
    issue(1'b1, 3, 32'hDEAD_BEEF, 0, 0);
    issue(1'b0, 3, '0, 1, 0);
    drain();

    // Backpressure: three reads fill the FIFO, the fourth waits.
    issue(1'b1, 0, 32'h1111_0000, 0, 0);
    issue(1'b1, 1, 32'h2222_0001, 0, 0);
    issue(1'b1, 2, 32'h3333_0002, 0, 0);
    rsp_rdy = 1'b0;
    issue(1'b0, 0, '0, 0, 1);
    issue(1'b0, 1, '0, 0, 1);
    issue(1'b0, 2, '0, 0, 1);
    fork
      issue(1'b0, 3, '0, 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
          check("bp_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        end
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
      end
    join
    drain();

    // Streaming: one read per cycle, no stalls.
    for (int a = 0; a < N; a++) issue(1'b1, a, 32'hC0DE_0000 + 32'(a), 0, 0);
    for (int i = 0; i < 64; i++) issue(1'b0, i % N, '0, 1, 1);
    drain();

    // Reset in the cycle after a read is accepted: the read must vanish.
    issue(1'b0, 5, '0, 0, 0);
    arst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    reset_values();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    init_check();
`ifndef SRAM_1RW_CTRL_INIT_EN
    issue(1'b1, 7, 32'h5A5A_0007, 0, 0);
`endif
    issue(1'b0, 7, '0, 1, 0);
    drain();

    check("max_outstanding_le_depth", (max_out <= RSP_DEPTH) ? 32'd1 : 32'd0, 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
